// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready handshake and flush
// Ports: clk, reset (sync, active-high); in_valid/in_ready/op/operand_a/operand_b/rd_id request side;
//        flush kills the op in flight; out_valid/out_ready/result/out_rd_id result side; busy = not idle.
// Optional: define MULDIV_EARLY_OUT_EN to skip leading-zero divide iterations and stop multiplies
//           once the remaining multiplier is zero (results unchanged, latency shrinks).
module muldiv_unit #(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_id,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_rd_id,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  state_t state;
  logic [CNT_W-1:0] cnt, div_cnt;
  logic [1:0] op_r;
  logic neg_q, neg_rem;
  logic [2*XLEN-1:0] acc, mcand, acc_nxt, prod;
  logic [XLEN-1:0] mplier, quo, rem, dvsr;
  logic a_signed, b_signed, sa, sb, div_zero, ovf, a_zero, mul_last;
  logic [XLEN-1:0] mag_a, mag_b, mc_init, mp_init, quo_init, special_res;
  logic [XLEN-1:0] mpl_nxt, rem_nxt, quo_nxt, mul_res, div_res;
  logic [XLEN:0] r_sh, diff;
  assign in_ready = state == IDLE && !reset;
  assign busy = state != IDLE;
  // Operands are kept as magnitudes; the sign is reapplied to the final result.
  assign a_signed = op[2] ? !op[0] : op[0] ^ op[1];
  assign b_signed = op[2] ? !op[0] : op[1:0] == 2'b01;
  assign sa = a_signed & operand_a[XLEN-1];
  assign sb = b_signed & operand_b[XLEN-1];
  assign mag_a = sa ? -operand_a : operand_a;
  assign mag_b = sb ? -operand_b : operand_b;
  assign div_zero = operand_b == '0;
  assign ovf = !op[0] && operand_a == MIN_NEG && &operand_b;
  assign special_res = div_zero ? (op[1] ? operand_a : '1) : ovf ? (op[1] ? '0 : MIN_NEG) : '0;
`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0] bit_len;
  always_comb begin
    bit_len = '0;
    for (int i = 0; i < XLEN; i++) bit_len = mag_a[i] ? CNT_W'(i + 1) : bit_len;
  end
  // Dividend is left-aligned so only its significant bits are iterated.
  assign a_zero = bit_len == '0;
  assign div_cnt = bit_len;
  assign quo_init = mag_a << (CNT_W'(XLEN) - bit_len);
  assign mc_init = mag_a < mag_b ? mag_b : mag_a;
  assign mp_init = mag_a < mag_b ? mag_a : mag_b;
  assign mul_last = cnt == CNT_W'(1) || mpl_nxt == '0;
`else
  assign a_zero = 1'b0;
  assign div_cnt = CNT_W'(XLEN);
  assign quo_init = mag_a;
  assign mc_init = mag_a;
  assign mp_init = mag_b;
  assign mul_last = cnt == CNT_W'(1);
`endif
  // Shift-add multiply: the multiplicand shifts left, the multiplier shifts right.
  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign mpl_nxt = mplier >> 1;
  assign prod = neg_q ? -acc_nxt : acc_nxt;
  assign mul_res = op_r == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  // Restoring divide: the dividend shifts out of quo's top while quotient bits enter at the bottom.
  assign r_sh = {rem, quo[XLEN-1]};
  assign diff = r_sh - {1'b0, dvsr};
  assign rem_nxt = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], !diff[XLEN]};
  assign div_res = op_r[1] ? (neg_rem ? -rem_nxt : rem_nxt) : (neg_q ? -quo_nxt : quo_nxt);
  // The last iteration writes its finished result straight into the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= '0;
      out_rd_id <= '0;
    end else if (flush) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r <= op[1:0];
          out_rd_id <= rd_id;
          neg_q <= sa ^ sb;
          neg_rem <= sa;
          acc <= '0;
          mcand <= {{XLEN{1'b0}}, mc_init};
          mplier <= mp_init;
          rem <= '0;
          quo <= quo_init;
          dvsr <= mag_b;
          cnt <= op[2] ? div_cnt : CNT_W'(XLEN);
          if (op[2] && (div_zero || ovf || a_zero)) begin
            state <= DONE;
            out_valid <= 1'b1;
            result <= special_res;
          end else begin
            state <= op[2] ? DIV : MUL;
          end
        end
        MUL: begin
          acc <= acc_nxt;
          mcand <= mcand << 1;
          mplier <= mpl_nxt;
          cnt <= cnt - 1'b1;
          if (mul_last) begin
            state <= DONE;
            out_valid <= 1'b1;
            result <= mul_res;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            out_valid <= 1'b1;
            result <= div_res;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [2:0] op = '0;
  logic [31:0] operand_a = '0, operand_b = '0, result;
  logic [4:0] rd_id = '0, out_rd_id;
  int checks = 0, failures = 0;
  int lat;
  always #5 clk = ~clk;
  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .rd_id(rd_id), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_rd_id(out_rd_id), .busy(busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint as_, bs_, bu;
    logic [63:0] pu;
    logic ovf;
    as_ = longint'($signed(a));
    bs_ = longint'($signed(b));
    bu = longint'(b);
    pu = 64'(a) * 64'(b);
    ovf = a == 32'h8000_0000 && b == 32'hffff_ffff;
    case (o)
      3'd0: return 32'(as_ * bs_);
      3'd1: return 32'((as_ * bs_) >>> 32);
      3'd2: return 32'((as_ * bu) >>> 32);
      3'd3: return pu[63:32];
      3'd4: return b == 0 ? 32'hffff_ffff : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return b == 0 ? 32'hffff_ffff : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic bit special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hffff_ffff));
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction
  // Issues one op, waits for its result, holds out_ready low for 'hold' cycles, then drains it.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold, output int l);
    logic [31:0] e;
    int el;
    e = model(o, a, b);
    el = special(o, a, b) ? 1 : 33;
    l = 0;
    out_ready = hold == 0;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; op = o; operand_a = a; operand_b = b; rd_id = rd;
    @(posedge clk);
    #1 in_valid = 1'b0; operand_a = $urandom; operand_b = $urandom; rd_id = 5'($urandom);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        l = k;
        break;
      end
    end
    check("out_valid", out_valid, 1);
    check($sformatf("result op%0d a=%h b=%h", o, a, b), result, e);
    check("out_rd_id", out_rd_id, rd);
`ifdef MULDIV_EARLY_OUT_EN
    check("latency_max", (l >= 1 && l <= el) ? el : l, el);
`else
    check("latency", l, el);
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
      @(negedge clk);
      check("hold_result", result, e);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_rd", out_rd_id, rd);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("drain_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_rd", out_rd_id, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    do_op(3'd0, 32'h7, 32'hffff_fffd, 5'd5, 0, lat);
    do_op(3'd1, 32'h8000_0000, 32'hffff_ffff, 5'd1, 0, lat);
    do_op(3'd2, 32'h8000_0000, 32'hffff_ffff, 5'd2, 0, lat);
    do_op(3'd3, 32'h8000_0000, 32'hffff_ffff, 5'd3, 0, lat);
    do_op(3'd4, 32'hffff_fff9, 32'h2, 5'd4, 0, lat);
    do_op(3'd6, 32'hffff_fff9, 32'h2, 5'd6, 0, lat);
    do_op(3'd5, 32'hffff_fffe, 32'h2, 5'd7, 0, lat);
    do_op(3'd5, 32'h5, 32'h0, 5'd8, 0, lat);
    do_op(3'd6, 32'h5, 32'h0, 5'd9, 0, lat);
    do_op(3'd4, 32'h8000_0000, 32'hffff_ffff, 5'd10, 0, lat);
    do_op(3'd6, 32'h8000_0000, 32'hffff_ffff, 5'd11, 0, lat);
    do_op(3'd0, 32'h1234_5678, 32'h9abc_def1, 5'd12, 10, lat);
    do_op(3'd7, 32'hdead_beef, 32'h0000_1234, 5'd13, 0, lat);
`ifdef MULDIV_EARLY_OUT_EN
    do_op(3'd5, 32'h1, 32'h1, 5'd14, 0, lat);
    check("early_divu_1_1", lat, 2);
`endif
    // flush in the fifth cycle of a divide
    @(negedge clk);
    in_valid = 1'b1; op = 3'd4; operand_a = 32'h7654_3210; operand_b = 32'h3; rd_id = 5'd15;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("flush_busy_before", busy, 1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("flush_no_valid", seen, 0);
    // flush coinciding with an accept drops the request
    in_valid = 1'b1; flush = 1'b1; op = 3'd0;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_accept_busy", busy, 0);
    for (int n = 0; n < 150; n++)
      do_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)), $urandom_range(0, 2), lat);
    // reset in the middle of a multiply
    do_op(3'd0, 32'h3, 32'h5, 5'd20, 0, lat);
    @(negedge clk);
    in_valid = 1'b1; op = 3'd3; operand_a = 32'hffff_0000; operand_b = 32'h1234; rd_id = 5'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_rd", out_rd_id, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    do_op(3'd1, 32'hffff_fff0, 32'h0000_0010, 5'd21, 0, lat);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
